// File: rtl/ones_comp_pkg.sv
// +----------------------------------------------------------------------------
// | Module   : ones_comp_pkg
// | Brief    : Shared types and one's-complement sign/magnitude helpers.
// | Revision : 1.0  initial release
// +----------------------------------------------------------------------------
`default_nettype none

package ones_comp_pkg;

    localparam int NUM_BIT = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } muldiv_op_t;

    // Helpers work on a 32-bit container; only the low 'width' bits are meaningful.
    function automatic logic [31:0] oc_to_mag(input logic [31:0] word, input int width);
        logic [31:0] mask;
        mask = (32'd1 << (width - 1)) - 32'd1;
        return (word[width-1] ? ~word : word) & mask;
    endfunction

    function automatic logic [31:0] mag_to_oc(input logic sign, input logic [31:0] mag,
                                              input int width);
        logic [31:0] mask;
        logic [31:0] res;
        mask = (32'd1 << (width - 1)) - 32'd1;
        res  = (sign ? ~mag : mag) & mask;
        if (sign) begin
            res = res | (32'd1 << (width - 1));
        end
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ones_comp_split.sv
// +----------------------------------------------------------------------------
// | Module   : ones_comp_split
// | Brief    : Combinational one's-complement word to {sign, magnitude}.
// | Revision : 1.0  initial release
// +----------------------------------------------------------------------------
`default_nettype none

module ones_comp_split
    import ones_comp_pkg::*;
#(
    parameter int WIDTH = NUM_BIT
) (
    input  logic [WIDTH-1:0] word,
    output logic             sign,
    output logic [WIDTH-2:0] mag
);

    assign sign = word[WIDTH-1];
    assign mag  = (WIDTH-1)'(oc_to_mag(32'(word), WIDTH));

endmodule

`default_nettype wire

// File: rtl/ones_comp_seq_muldiv.sv
// +----------------------------------------------------------------------------
// | Module   : ones_comp_seq_muldiv
// | Brief    : Iterative one's-complement multiply / restoring divide, start/done.
// |            Optional divide-overflow detection: define ONES_COMP_MULDIV_OVF_EN.
// | Revision : 1.0  initial release
// +----------------------------------------------------------------------------
`default_nettype none

module ones_comp_seq_muldiv
    import ones_comp_pkg::*;
#(
    parameter int WIDTH = NUM_BIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] x_hi,
    input  logic [WIDTH-1:0] x_lo,
    input  logic [WIDTH-1:0] y,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             ovf
);

    localparam int                 c_mag_w     = WIDTH - 1;
    localparam int                 c_cnt_w     = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_iter = c_cnt_w'(WIDTH - 2);
    localparam logic [c_mag_w-1:0] c_mag_max   = '1;

    muldiv_state_t      r_state;
    muldiv_state_t      w_next;
    muldiv_op_t         r_op;
    muldiv_op_t         w_op;
    logic [c_cnt_w-1:0] r_cnt;
    // acc: product high half / partial remainder; shf: multiplier+product low / dividend+quotient
    logic [c_mag_w-1:0] r_acc;
    logic [c_mag_w-1:0] r_shf;
    logic [c_mag_w-1:0] r_opb;
    logic               r_sq;
    logic               r_sr;
    logic [WIDTH-1:0]   r_res_hi;
    logic [WIDTH-1:0]   r_res_lo;

    logic               w_xh_sign;
    logic               w_xl_sign;
    logic               w_y_sign;
    logic [c_mag_w-1:0] w_xh_mag;
    logic [c_mag_w-1:0] w_xl_mag;
    logic [c_mag_w-1:0] w_y_mag;
    logic               w_div_sign;
    logic               w_accept;
    logic               w_ovf_chk;
    logic               w_ovf_hit;
    logic [c_mag_w-1:0] w_addend;
    logic [c_mag_w:0]   w_sum;
    logic [c_mag_w:0]   w_trial;
    logic [c_mag_w:0]   w_sub;
    logic               w_no_borrow;

    ones_comp_split #(.WIDTH(WIDTH)) u_split_xh (.word(x_hi), .sign(w_xh_sign), .mag(w_xh_mag));
    ones_comp_split #(.WIDTH(WIDTH)) u_split_xl (.word(x_lo), .sign(w_xl_sign), .mag(w_xl_mag));
    ones_comp_split #(.WIDTH(WIDTH)) u_split_y  (.word(y),    .sign(w_y_sign),  .mag(w_y_mag));

    assign w_op       = muldiv_op_t'(op);
    assign w_accept   = (r_state == IDLE) && start;
    // A zero high word (either polarity) carries no sign, so the low word decides.
    assign w_div_sign = (w_xh_mag == '0) ? w_xl_sign : w_xh_sign;

`ifdef ONES_COMP_MULDIV_OVF_EN
    logic r_ovf;

    assign w_ovf_chk = (w_op == OP_DIV) && (w_xh_mag >= w_y_mag);
    assign w_ovf_hit = r_ovf;
    assign ovf       = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= w_ovf_chk;
        end
    end
`else
    assign w_ovf_chk = 1'b0;
    assign w_ovf_hit = 1'b0;
    assign ovf       = 1'b0;
`endif

    assign w_addend    = r_shf[0] ? r_opb : '0;
    assign w_sum       = {1'b0, r_acc} + {1'b0, w_addend};
    assign w_trial     = {r_acc, r_shf[c_mag_w-1]};
    assign w_no_borrow = (w_trial >= {1'b0, r_opb});
    assign w_sub       = w_trial - {1'b0, r_opb};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = w_ovf_chk ? FIX : CALC;
                end
            end
            CALC: begin
                if (r_cnt == c_last_iter) begin
                    w_next = FIX;
                end
            end
            FIX:     w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            CALC, FIX: busy = 1'b1;
            DONE:      done = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op     <= OP_MULT;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_shf    <= '0;
            r_opb    <= '0;
            r_sq     <= 1'b0;
            r_sr     <= 1'b0;
            r_res_hi <= '0;
            r_res_lo <= '0;
        end else if (w_accept) begin
            r_op  <= w_op;
            r_cnt <= '0;
            if (w_op == OP_DIV) begin
                r_acc <= w_xh_mag;
                r_shf <= w_xl_mag;
                r_opb <= w_y_mag;
                r_sq  <= w_div_sign ^ w_y_sign;
                // On overflow the low result word echoes x_lo, so keep its own sign.
                r_sr  <= w_ovf_chk ? w_xl_sign : w_div_sign;
            end else begin
                r_acc <= '0;
                r_shf <= w_y_mag;
                r_opb <= w_xl_mag;
                r_sq  <= w_xl_sign ^ w_y_sign;
                r_sr  <= w_xl_sign ^ w_y_sign;
            end
        end else if (r_state == CALC) begin
            r_cnt <= r_cnt + c_cnt_w'(1);
            if (r_op == OP_MULT) begin
                r_acc <= w_sum[c_mag_w:1];
                r_shf <= {w_sum[0], r_shf[c_mag_w-1:1]};
            end else begin
                r_acc <= c_mag_w'(w_no_borrow ? w_sub : w_trial);
                r_shf <= {r_shf[c_mag_w-2:0], w_no_borrow};
            end
        end else if (r_state == FIX) begin
            if (w_ovf_hit) begin
                r_res_hi <= WIDTH'(mag_to_oc(r_sq, 32'(c_mag_max), WIDTH));
                r_res_lo <= WIDTH'(mag_to_oc(r_sr, 32'(r_shf), WIDTH));
            end else if (r_op == OP_MULT) begin
                r_res_hi <= WIDTH'(mag_to_oc(r_sq, 32'(r_acc), WIDTH));
                r_res_lo <= WIDTH'(mag_to_oc(r_sr, 32'(r_shf), WIDTH));
            end else begin
                r_res_hi <= WIDTH'(mag_to_oc(r_sq, 32'(r_shf), WIDTH));
                r_res_lo <= WIDTH'(mag_to_oc(r_sr, 32'(r_acc), WIDTH));
            end
        end
    end

    assign res_hi = r_res_hi;
    assign res_lo = r_res_lo;

endmodule

`default_nettype wire

// File: tb/tb_ones_comp_seq_muldiv.sv
// +----------------------------------------------------------------------------
// | Module   : tb_ones_comp_seq_muldiv
// | Brief    : Directed vector bench for ones_comp_seq_muldiv at WIDTH=15.
// | Revision : 1.0  initial release
// +----------------------------------------------------------------------------
`default_nettype none

module tb_ones_comp_seq_muldiv;

    localparam int W = 15;

    typedef struct {
        logic         op;
        logic [W-1:0] xhi;
        logic [W-1:0] xlo;
        logic [W-1:0] yy;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         op;
    logic [W-1:0] x_hi;
    logic [W-1:0] x_lo;
    logic [W-1:0] y;
    logic         busy;
    logic         done;
    logic [W-1:0] res_hi;
    logic [W-1:0] res_lo;
    logic         ovf;

    int n_pass;
    int n_total;

    vec_t vecs[11];

    ones_comp_seq_muldiv #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op),
        .x_hi(x_hi), .x_lo(x_lo), .y(y),
        .busy(busy), .done(done), .res_hi(res_hi), .res_lo(res_lo), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0o expected %0o", name, act, exp);
        end
    endtask

    // Launch one operation, scramble inputs after accept, and count cycles until done.
    task automatic run_op(input logic o, input logic [W-1:0] xh, input logic [W-1:0] xl,
                          input logic [W-1:0] yy, output int cyc, output logic busy_ok);
        @(negedge clk);
        start = 1'b1; op = o; x_hi = xh; x_lo = xl; y = yy;
        @(negedge clk);
        start = 1'b0; op = ~o;
        x_hi = W'($urandom); x_lo = W'($urandom); y = W'($urandom);
        cyc = 1;
        busy_ok = 1'b1;
        while (!done && cyc < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            cyc++;
        end
        if (busy) busy_ok = 1'b0;
    endtask

    initial begin
        int   cyc;
        logic bok;

        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0; start = 1'b0; op = 1'b0;
        x_hi = '0; x_lo = '0; y = '0;

        vecs[0]  = '{1'b0, 15'o00000, 15'o00003, 15'o77775, 15'o77777, 15'o77771};
        vecs[1]  = '{1'b1, 15'o00000, 15'o00144, 15'o00007, 15'o00016, 15'o00002};
        vecs[2]  = '{1'b1, 15'o77777, 15'o77633, 15'o00007, 15'o77761, 15'o77775};
        vecs[3]  = '{1'b0, 15'o00000, 15'o01000, 15'o00100, 15'o00002, 15'o00000};
        vecs[4]  = '{1'b0, 15'o00000, 15'o37777, 15'o37777, 15'o37776, 15'o00001};
        vecs[5]  = '{1'b0, 15'o00000, 15'o00000, 15'o77776, 15'o77777, 15'o77777};
        vecs[6]  = '{1'b0, 15'o00000, 15'o77777, 15'o77772, 15'o00000, 15'o00000};
        vecs[7]  = '{1'b0, 15'o00000, 15'o77770, 15'o77771, 15'o00000, 15'o00052};
        vecs[8]  = '{1'b1, 15'o00001, 15'o00000, 15'o00003, 15'o12525, 15'o00001};
        vecs[9]  = '{1'b1, 15'o00000, 15'o00144, 15'o77770, 15'o77761, 15'o00002};
        vecs[10] = '{1'b1, 15'o37776, 15'o37777, 15'o37777, 15'o37777, 15'o37776};

        repeat (2) @(negedge clk);
        check("reset_busy",   32'(busy),   32'd0);
        check("reset_done",   32'(done),   32'd0);
        check("reset_ovf",    32'(ovf),    32'd0);
        check("reset_res_hi", 32'(res_hi), 32'd0);
        check("reset_res_lo", 32'(res_lo), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].op, vecs[i].xhi, vecs[i].xlo, vecs[i].yy, cyc, bok);
            check($sformatf("v%0d_latency", i), 32'(cyc),    32'd16);
            check($sformatf("v%0d_busy",    i), 32'(bok),    32'd1);
            check($sformatf("v%0d_res_hi",  i), 32'(res_hi), 32'(vecs[i].exp_hi));
            check($sformatf("v%0d_res_lo",  i), 32'(res_lo), 32'(vecs[i].exp_lo));
            check($sformatf("v%0d_ovf",     i), 32'(ovf),    32'd0);
        end

        // Results must hold in idle after done.
        @(negedge clk);
        @(negedge clk);
        check("hold_res_hi", 32'(res_hi), 32'(15'o37777));
        check("hold_res_lo", 32'(res_lo), 32'(15'o37776));

`ifdef ONES_COMP_MULDIV_OVF_EN
        run_op(1'b1, 15'o00010, 15'o01234, 15'o00007, cyc, bok);
        check("ovf_latency", 32'(cyc),    32'd2);
        check("ovf_busy",    32'(bok),    32'd1);
        check("ovf_flag",    32'(ovf),    32'd1);
        check("ovf_res_hi",  32'(res_hi), 32'(15'o37777));
        check("ovf_res_lo",  32'(res_lo), 32'(15'o01234));
        run_op(1'b1, 15'o00000, 15'o00005, 15'o00000, cyc, bok);
        check("div0_flag",   32'(ovf),    32'd1);
        check("div0_res_hi", 32'(res_hi), 32'(15'o37777));
        check("div0_res_lo", 32'(res_lo), 32'(15'o00005));
        run_op(1'b1, 15'o77767, 15'o55555, 15'o00007, cyc, bok);
        check("ovfn_res_hi", 32'(res_hi), 32'(15'o40000));
        check("ovfn_res_lo", 32'(res_lo), 32'(15'o55555));
        run_op(1'b0, 15'o00000, 15'o00003, 15'o00003, cyc, bok);
        check("ovf_clear",   32'(ovf),    32'd0);
        check("ovf_mult_lo", 32'(res_lo), 32'(15'o00011));
`endif

        // start pulses in cycles 5 and 16 of a multiply must be ignored
        @(negedge clk);
        start = 1'b1; op = 1'b0; x_hi = '0; x_lo = 15'o00003; y = 15'o77775;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (c == 5) begin
                start = 1'b1; x_lo = 15'o00100; y = 15'o00100;
            end
            @(negedge clk);
            start = 1'b0;
        end
        check("busy_start_done_c16", 32'(done), 32'd1);
        start = 1'b1; x_lo = 15'o00007; y = 15'o00007;
        @(negedge clk);
        check("busy_start_c17_busy", 32'(busy),   32'd0);
        check("busy_start_res_hi",   32'(res_hi), 32'(15'o77777));
        check("busy_start_res_lo",   32'(res_lo), 32'(15'o77771));
        x_lo = 15'o00005; y = 15'o00006;
        @(negedge clk);
        start = 1'b0;
        check("accept_c17_busy", 32'(busy), 32'd1);
        cyc = 1;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("accept_c17_latency", 32'(cyc),    32'd16);
        check("accept_c17_res_hi",  32'(res_hi), 32'(15'o00000));
        check("accept_c17_res_lo",  32'(res_lo), 32'(15'o00036));

        // reset in cycle 8 of a divide
        @(negedge clk);
        start = 1'b1; op = 1'b1; x_hi = '0; x_lo = 15'o00144; y = 15'o00007;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_busy",   32'(busy),   32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_ovf",    32'(ovf),    32'd0);
        check("rst_res_hi", 32'(res_hi), 32'd0);
        check("rst_res_lo", 32'(res_lo), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(1'b0, 15'o00000, 15'o00003, 15'o77775, cyc, bok);
        check("post_rst_latency", 32'(cyc),    32'd16);
        check("post_rst_res_hi",  32'(res_hi), 32'(15'o77777));
        check("post_rst_res_lo",  32'(res_lo), 32'(15'o77771));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
